// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: per-stage hold/clear controls derived combinationally from this cycle's hazards.
// Zero-cycle latency on controls; mem_wait freezes the whole pipe, FSM and rem included.
module pipeline_hazard_ctrl #(
   parameter int MULDIV_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        br_taken,
   input  logic        ex_muldiv_start,
   input  logic        mem_wait,
   output logic        bubbleF,
   output logic        bubbleD,
   output logic        bubbleE,
   output logic        bubbleM,
   output logic        bubbleW,
   output logic        flushF,
   output logic        flushD,
   output logic        flushE,
   output logic        flushM,
   output logic        flushW,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   typedef enum logic {RUN, MULDIV} state_t;

   localparam logic [3:0] REM_INIT = 4'(MULDIV_LAT - 2);

   state_t     state;
   logic [3:0] rem;
   logic       load_use;
   logic       muldiv_stall;
   logic       br_flush;

   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd)));

   // A start seen in MULDIV is redundant: the stall is already running.
   assign muldiv_stall = (state == MULDIV) || ex_muldiv_start;

   always_comb begin
      bubbleF  = 1'b0;
      bubbleD  = 1'b0;
      bubbleE  = 1'b0;
      bubbleM  = 1'b0;
      bubbleW  = 1'b0;
      flushF   = 1'b0;
      flushD   = 1'b0;
      flushE   = 1'b0;
      flushM   = 1'b0;
      flushW   = 1'b0;
      br_flush = 1'b0;
      if (rst) begin
         flushF = 1'b1;
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
         flushW = 1'b1;
      end else if (mem_wait) begin
         bubbleF = 1'b1;
         bubbleD = 1'b1;
         bubbleE = 1'b1;
         bubbleM = 1'b1;
         bubbleW = 1'b1;
      end else if (muldiv_stall) begin
         bubbleF = 1'b1;
         bubbleD = 1'b1;
         bubbleE = 1'b1;
         flushM  = 1'b1;
      end else if (br_taken) begin
         flushD   = 1'b1;
         flushE   = 1'b1;
         br_flush = 1'b1;
      end else if (load_use) begin
         bubbleF = 1'b1;
         bubbleD = 1'b1;
         flushE  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         rem       <= 4'd0;
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (bubbleF)
            stall_cnt <= stall_cnt + 32'd1;
         if (br_flush)
            flush_cnt <= flush_cnt + 32'd1;
         if (!mem_wait) begin
            case (state)
               RUN: begin
                  if (ex_muldiv_start) begin
                     state <= MULDIV;
                     rem   <= REM_INIT;
                  end
               end
               MULDIV: begin
                  if (rem == 4'd0)
                     state <= RUN;
                  else
                     rem <= rem - 4'd1;
               end
               default: state <= RUN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MULDIV_LAT=4; hand-computed expectations.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_rs1_used, id_rs2_used, ex_mem_read;
   logic        br_taken, ex_muldiv_start, mem_wait;
   logic        bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
   logic        flushF, flushD, flushE, flushM, flushW;
   logic [31:0] stall_cnt, flush_cnt;

   int tests  = 0;
   int failed = 0;

   // {bubbleF,D,E,M,W, flushF,D,E,M,W}
   localparam logic [9:0] O_NONE = 10'b00000_00000;
   localparam logic [9:0] O_RST  = 10'b00000_11111;
   localparam logic [9:0] O_LU   = 10'b11000_00100;
   localparam logic [9:0] O_MD   = 10'b11100_00010;
   localparam logic [9:0] O_BR   = 10'b00000_01100;
   localparam logic [9:0] O_FRZ  = 10'b11111_00000;

   logic [9:0] ctl;
   assign ctl = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
                 flushF, flushD, flushE, flushM, flushW};

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MULDIV_LAT(4)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .br_taken(br_taken), .ex_muldiv_start(ex_muldiv_start), .mem_wait(mem_wait),
      .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE), .bubbleM(bubbleM), .bubbleW(bubbleW),
      .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr;
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
      br_taken = 1'b0; ex_muldiv_start = 1'b0; mem_wait = 1'b0;
   endtask

   task automatic set_lu_rs1;
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
   endtask

   initial begin
      clr();
      rst = 1'b1;
      tick(); tick();
      check("reset_ctl", 32'(ctl), 32'(O_RST));
      check("reset_stall_cnt", stall_cnt, 32'd0);
      check("reset_flush_cnt", flush_cnt, 32'd0);
      rst = 1'b0;
      #2 check("idle_ctl", 32'(ctl), 32'(O_NONE));

      // load-use on rs1, one cycle
      tick();
      set_lu_rs1();
      #2 check("lu_rs1_ctl", 32'(ctl), 32'(O_LU));
      tick();
      clr();
      check("lu_rs1_stall_cnt", stall_cnt, 32'd1);
      #2 check("lu_rs1_released", 32'(ctl), 32'(O_NONE));

      // no hazard when rd is x0 or source unused
      set_lu_rs1(); ex_rd = 5'd0; id_rs1 = 5'd0;
      #1 check("lu_rd_x0", 32'(ctl), 32'(O_NONE));
      set_lu_rs1(); id_rs1_used = 1'b0;
      #1 check("lu_rs1_unused", 32'(ctl), 32'(O_NONE));
      clr(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
      #1 check("lu_not_load_is_used_only", 32'(ctl), 32'(O_NONE));

      // load-use on rs2
      tick();
      clr(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
      #2 check("lu_rs2_ctl", 32'(ctl), 32'(O_LU));
      tick();
      clr();
      check("lu_rs2_stall_cnt", stall_cnt, 32'd2);

      // mul/div start with simultaneous branch: treated as mul/div, 4 stall cycles
      ex_muldiv_start = 1'b1; br_taken = 1'b1;
      #2 check("md_c0", 32'(ctl), 32'(O_MD));
      tick(); clr(); br_taken = 1'b1;
      #2 check("md_c1_br_ignored", 32'(ctl), 32'(O_MD));
      tick(); clr(); ex_muldiv_start = 1'b1;
      #2 check("md_c2_start_ignored", 32'(ctl), 32'(O_MD));
      tick(); clr();
      #2 check("md_c3", 32'(ctl), 32'(O_MD));
      tick();
      #2 check("md_done", 32'(ctl), 32'(O_NONE));
      check("md_stall_cnt", stall_cnt, 32'd6);
      check("md_flush_cnt", flush_cnt, 32'd0);

      // branch overrides load-use
      br_taken = 1'b1; set_lu_rs1();
      #2 check("br_over_lu_ctl", 32'(ctl), 32'(O_BR));
      tick(); clr();
      check("br_flush_cnt", flush_cnt, 32'd1);
      check("br_stall_cnt", stall_cnt, 32'd6);

      // mem_wait beats branch: freeze, no flush counted
      mem_wait = 1'b1; br_taken = 1'b1;
      #2 check("frz_over_br_ctl", 32'(ctl), 32'(O_FRZ));
      tick(); clr();
      check("frz_flush_cnt", flush_cnt, 32'd1);
      check("frz_stall_cnt", stall_cnt, 32'd7);

      // mul/div with two mem_wait cycles from cycle 1: 6 stall cycles in total
      ex_muldiv_start = 1'b1;
      #2 check("mdw_c0", 32'(ctl), 32'(O_MD));
      tick(); clr(); mem_wait = 1'b1;
      #2 check("mdw_c1_frz", 32'(ctl), 32'(O_FRZ));
      tick();
      #2 check("mdw_c2_frz", 32'(ctl), 32'(O_FRZ));
      tick(); clr();
      #2 check("mdw_c3", 32'(ctl), 32'(O_MD));
      tick();
      #2 check("mdw_c4", 32'(ctl), 32'(O_MD));
      tick();
      #2 check("mdw_c5", 32'(ctl), 32'(O_MD));
      tick();
      #2 check("mdw_done", 32'(ctl), 32'(O_NONE));
      check("mdw_stall_cnt", stall_cnt, 32'd13);

      // reset during mul/div cycle 2 aborts the op
      ex_muldiv_start = 1'b1;
      tick(); clr();
      tick();
      rst = 1'b1;
      #2 check("rst_md_ctl", 32'(ctl), 32'(O_RST));
      tick();
      check("rst_md_stall_cnt", stall_cnt, 32'd0);
      check("rst_md_flush_cnt", flush_cnt, 32'd0);
      rst = 1'b0;
      #2 check("rst_md_after_ctl", 32'(ctl), 32'(O_NONE));
      tick();
      #2 check("rst_md_run_ctl", 32'(ctl), 32'(O_NONE));
      check("rst_md_run_stall_cnt", stall_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MULDIV_LAT, default 4, meaning the number of consecutive stall cycles a multi-cycle mul/div op imposes (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning a synchronous, active-high reset.
REQ-004 The block SHALL have ports id_rs1 and id_rs2, input, 5 each, meaning the source register numbers of the instruction in ID.
REQ-005 The block SHALL have ports id_rs1_used and id_rs2_used, input, 1 each, meaning the corresponding source register is actually read.
REQ-006 The block SHALL have port ex_rd, input, 5, meaning the destination register of the instruction in EX.
REQ-007 The block SHALL have port ex_mem_read, input, 1, meaning the instruction in EX is a load.
REQ-008 The block SHALL have port br_taken, input, 1, meaning the instruction in EX is a taken branch or jump this cycle.
REQ-009 The block SHALL have port ex_muldiv_start, input, 1, meaning a mul/div op enters EX this cycle.
REQ-010 The block SHALL have port mem_wait, input, 1, meaning data memory is not ready this cycle.
REQ-011 The block SHALL have ports bubbleF, bubbleD, bubbleE, bubbleM and bubbleW, output, 1 each, meaning hold the corresponding stage register.
REQ-012 The block SHALL have ports flushF, flushD, flushE, flushM and flushW, output, 1 each, meaning clear the corresponding stage register to a NOP.
REQ-013 The block SHALL have ports stall_cnt and flush_cnt, output, 32 each, meaning performance counters.

Function
REQ-014 The block SHALL implement FSM states RUN and MULDIV, plus a 4-bit remaining-cycle counter rem.
REQ-015 Stall/flush outputs SHALL be combinational from the current inputs and state, with zero-cycle latency; the stages register them themselves.
REQ-016 Load-use hazard SHALL be defined as ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
REQ-017 Priority, highest first: mem_wait freeze, mul/div stall, branch flush, load-use stall; only the highest active condition drives outputs.
REQ-018 mem_wait freeze: bubbleF/D/E/M/W=1, all flushes=0; FSM and rem SHALL hold their values.
REQ-019 Mul/div stall (ex_muldiv_start in RUN, or state MULDIV): bubbleF/D/E=1, flushM=1, all others 0.
REQ-020 On ex_muldiv_start in RUN without mem_wait: next state MULDIV, rem<=MULDIV_LAT-2.
REQ-021 In MULDIV without mem_wait: if rem==0 go to RUN, else rem<=rem-1; total stall is exactly MULDIV_LAT cycles including the start cycle.
REQ-022 ex_muldiv_start SHALL be ignored while in MULDIV.
REQ-023 Branch flush (br_taken in RUN without muldiv start): flushD=1, flushE=1, all bubbles 0; branch SHALL override a simultaneous load-use hazard.
REQ-024 br_taken asserted together with ex_muldiv_start SHALL be treated as mul/div; br_taken in MULDIV SHALL be ignored.
REQ-025 Load-use stall: bubbleF=1, bubbleD=1, flushE=1, all others 0.
REQ-026 No condition active: all outputs 0.
REQ-027 stall_cnt SHALL increment by 1 every cycle bubbleF=1 and rst=0; flush_cnt SHALL increment by 1 every branch-flush cycle; both wrap 0xFFFFFFFF->0.

Reset
REQ-028 While rst=1: state<=RUN, rem<=0, stall_cnt<=0, flush_cnt<=0, all bubbles=0, all flushes=1.
REQ-029 Reset asserted mid-MULDIV SHALL abort the op; the first cycle after reset is RUN with no stall.

Verification
REQ-030 Bench: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> bubbleF=bubbleD=flushE=1 for 1 cycle; stall_cnt 0->1.
REQ-031 Bench: same as REQ-030 but ex_rd=0, or id_rs1_used=0 -> all outputs 0.
REQ-032 Bench: ex_muldiv_start pulse with MULDIV_LAT=4 -> bubbleF/D/E and flushM high for exactly cycles 0..3; stall_cnt=4.
REQ-033 Bench: mem_wait=1 for 2 cycles during MULDIV cycle 1 -> all bubbles high for those 2 cycles; mul/div stall resumes, 6 stall cycles in total.
REQ-034 Bench: br_taken=1 together with a load-use hazard -> flushD=flushE=1, bubbleF=0; flush_cnt +1.
REQ-035 Bench: rst=1 in MULDIV cycle 2 -> all flushes=1 and counters 0; after release, outputs 0 and state RUN.
